// File: rtl/ddr_burst_arbiter_if.sv
// ddr_burst_arbiter_if: requester-side and MIG app-side bundle; master = arbiter, slave = requesters + MIG
interface ddr_burst_arbiter_if #(
  parameter int NUM_CH = 3,
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int LEN_WIDTH = 10
);
  logic init_calib_complete;
  logic [NUM_CH-1:0] ch_rd_req;
  logic [NUM_CH-1:0] ch_wr_req;
  logic [NUM_CH*DDR_ADDR_WIDTH-1:0] ch_addr;
  logic [NUM_CH*LEN_WIDTH-1:0] ch_len;
  logic [NUM_CH*DDR_DATA_WIDTH-1:0] ch_wr_data;
  logic [NUM_CH-1:0] ch_grant;
  logic [NUM_CH-1:0] ch_wr_data_req;
  logic [DDR_DATA_WIDTH-1:0] ch_rd_data;
  logic [NUM_CH-1:0] ch_rd_data_valid;
  logic [NUM_CH-1:0] ch_done;
  logic app_en;
  logic [2:0] app_cmd;
  logic [DDR_ADDR_WIDTH-1:0] app_addr;
  logic app_wdf_wren;
  logic app_wdf_end;
  logic [DDR_DATA_WIDTH-1:0] app_wdf_data;
  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask;
  logic app_rdy;
  logic app_wdf_rdy;
  logic app_rd_data_valid;
  logic [DDR_DATA_WIDTH-1:0] app_rd_data;
  modport master (
    input init_calib_complete, ch_rd_req, ch_wr_req, ch_addr, ch_len, ch_wr_data,
    input app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    output ch_grant, ch_wr_data_req, ch_rd_data, ch_rd_data_valid, ch_done,
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
  );
  modport slave (
    output init_calib_complete, ch_rd_req, ch_wr_req, ch_addr, ch_len, ch_wr_data,
    output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    input ch_grant, ch_wr_data_req, ch_rd_data, ch_rd_data_valid, ch_done,
    input app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
  );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: round-robin N-channel burst front-end for the MIG app interface
// define DDR_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin
module ddr_burst_arbiter #(
  parameter int NUM_CH = 3,
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int LEN_WIDTH = 10,
  parameter int ADDR_STEP = 8
) (
  input logic clk,
  input logic rst,
  ddr_burst_arbiter_if.master bus
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = LEN_WIDTH + 1;
  localparam logic [2:0] IDLE = 3'd0, ARB = 3'd1, RD = 3'd2, WR = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [PW-1:0] rr, owner, win;
  logic [DDR_ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0] len;
  logic [CW-1:0] cmd_cnt, ret_cnt;
  logic [NUM_CH-1:0] req, grant, rd_valid, owner_oh, win_oh;
  logic [DDR_DATA_WIDTH-1:0] rd_data;
  logic more, rd_acc, wr_acc, ret;
  assign req = bus.ch_rd_req | bus.ch_wr_req;
  assign owner_oh = NUM_CH'(1) << owner;
  assign win_oh = NUM_CH'(1) << win;
`ifdef DDR_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[i]) win = PW'(i);
  end
`else
  // scan farthest-first so the nearest requester after rr overwrites last
  always_comb begin
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[(int'(rr) + i) % NUM_CH]) win = PW'((int'(rr) + i) % NUM_CH);
  end
`endif
  assign more = cmd_cnt < CW'(len);
  assign rd_acc = state == RD && more && bus.app_rdy;
  assign wr_acc = state == WR && more && bus.app_rdy && bus.app_wdf_rdy;
  assign ret = state == RD && bus.app_rd_data_valid;
  assign bus.app_en = (state == RD || state == WR) && more;
  assign bus.app_cmd = state == RD && more ? 3'b001 : 3'b000;
  assign bus.app_addr = addr;
  assign bus.app_wdf_wren = state == WR && more;
  assign bus.app_wdf_end = state == WR && more;
  assign bus.app_wdf_mask = '0;
  assign bus.app_wdf_data = state == WR ? bus.ch_wr_data[owner*DDR_DATA_WIDTH +: DDR_DATA_WIDTH] : '0;
  assign bus.ch_wr_data_req = wr_acc ? owner_oh : '0;
  assign bus.ch_grant = grant;
  assign bus.ch_rd_data = rd_data;
  assign bus.ch_rd_data_valid = rd_valid;
  assign bus.ch_done = state == DONE ? owner_oh : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr <= '0;
      owner <= '0;
      addr <= '0;
      len <= '0;
      cmd_cnt <= '0;
      ret_cnt <= '0;
      grant <= '0;
      rd_valid <= '0;
      rd_data <= '0;
    end else begin
      rd_valid <= ret ? owner_oh : '0;
      if (ret) rd_data <= bus.app_rd_data;
      case (state)
        IDLE: if (bus.init_calib_complete && |req) state <= ARB;
        ARB: begin
          if (|req) begin
            owner <= win;
            rr <= win == PW'(NUM_CH - 1) ? '0 : win + 1'b1;
            addr <= bus.ch_addr[win*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
            len <= bus.ch_len[win*LEN_WIDTH +: LEN_WIDTH];
            grant <= win_oh;
            cmd_cnt <= '0;
            ret_cnt <= '0;
            state <= bus.ch_len[win*LEN_WIDTH +: LEN_WIDTH] == '0 ? DONE : bus.ch_rd_req[win] ? RD : WR;
          end else state <= IDLE;
        end
        RD: begin
          if (rd_acc) begin
            addr <= addr + DDR_ADDR_WIDTH'(ADDR_STEP);
            cmd_cnt <= cmd_cnt + 1'b1;
          end
          if (ret) begin
            ret_cnt <= ret_cnt + 1'b1;
            if (ret_cnt + 1'b1 == CW'(len)) state <= DONE;
          end
        end
        WR: if (wr_acc) begin
          addr <= addr + DDR_ADDR_WIDTH'(ADDR_STEP);
          cmd_cnt <= cmd_cnt + 1'b1;
          if (cmd_cnt + 1'b1 == CW'(len)) state <= DONE;
        end
        DONE: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter: directed vectors with hand-computed expectations
module tb_ddr_burst_arbiter;
  localparam int NC = 3, DW = 128, AW = 28, LW = 10;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [27:0] wa [4] = '{28'h200, 28'h208, 28'h208, 28'h210};
  logic [3:0] wp = 4'b1101;
`ifdef DDR_ARB_FIXED_PRIO_EN
  logic [2:0] rr_exp [4] = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
  logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
  always #5 clk = ~clk;
  ddr_burst_arbiter_if #(.NUM_CH(NC), .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();
  ddr_burst_arbiter #(.NUM_CH(NC), .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ADDR_STEP(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ch(input int c, input logic [27:0] a, input logic [9:0] l);
    bus.ch_addr[c*AW +: AW] = a;
    bus.ch_len[c*LW +: LW] = l;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.init_calib_complete = 0;
    bus.ch_rd_req = '0;
    bus.ch_wr_req = '0;
    bus.ch_addr = '0;
    bus.ch_len = '0;
    bus.ch_wr_data = '0;
    bus.ch_wr_data[2*DW +: DW] = 128'hC2C2_0000_1111_2222_3333_4444_5555_6666;
    bus.app_rdy = 1;
    bus.app_wdf_rdy = 1;
    bus.app_rd_data_valid = 0;
    bus.app_rd_data = '0;
    repeat (3) tick();
    chk("rst grant", bus.ch_grant, 0);
    chk("rst app_en", bus.app_en, 0);
    chk("rst app_addr", bus.app_addr, 0);
    chk("rst done", bus.ch_done, 0);
    rst = 1;
    set_ch(0, 28'h40, 1);
    bus.ch_rd_req = 3'b001;
    repeat (3) tick();
    chk("nocal grant", bus.ch_grant, 0);
    chk("nocal app_en", bus.app_en, 0);
    bus.init_calib_complete = 1;
    tick();
    chk("cal arb grant", bus.ch_grant, 0);
    tick();
    chk("cal grant", bus.ch_grant, 3'b001);
    bus.ch_rd_req = '0;
    #1;
    chk("cal app_en", bus.app_en, 1);
    chk("cal app_cmd", bus.app_cmd, 3'b001);
    chk("cal app_addr", bus.app_addr, 28'h40);
    tick();
    chk("cal app_en off", bus.app_en, 0);
    bus.app_rd_data_valid = 1;
    bus.app_rd_data = 128'hAA;
    tick();
    bus.app_rd_data_valid = 0;
    chk("cal rd_valid", bus.ch_rd_data_valid, 3'b001);
    chk("cal rd_data", bus.ch_rd_data, 128'hAA);
    chk("cal done", bus.ch_done, 3'b001);
    tick();
    chk("cal done off", bus.ch_done, 0);
    chk("cal grant off", bus.ch_grant, 0);
    set_ch(1, 28'h100, 4);
    bus.ch_rd_req = 3'b010;
    tick();
    tick();
    chk("rd grant", bus.ch_grant, 3'b010);
    bus.ch_rd_req = '0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rd app_addr", bus.app_addr, 28'h100 + 28'(8 * i));
      chk("rd app_en", bus.app_en, 1);
      chk("rd app_cmd", bus.app_cmd, 3'b001);
      bus.app_rd_data_valid = (i == 3);
      bus.app_rd_data = 128'hD0;
      tick();
    end
    chk("rd app_en off", bus.app_en, 0);
    chk("rd valid0", bus.ch_rd_data_valid, 3'b010);
    chk("rd data0", bus.ch_rd_data, 128'hD0);
    bus.app_rd_data_valid = 0;
    tick();
    chk("rd valid gap", bus.ch_rd_data_valid, 0);
    for (int j = 1; j < 4; j++) begin
      bus.app_rd_data_valid = 1;
      bus.app_rd_data = 128'hD0 + 128'(j);
      tick();
      chk("rd valid", bus.ch_rd_data_valid, 3'b010);
      chk("rd data", bus.ch_rd_data, 128'hD0 + 128'(j));
      chk("rd done", bus.ch_done, j == 3 ? 3'b010 : 3'b000);
    end
    bus.app_rd_data_valid = 0;
    tick();
    chk("rd done once", bus.ch_done, 0);
    chk("rd grant off", bus.ch_grant, 0);
    set_ch(2, 28'h200, 3);
    bus.ch_wr_req = 3'b100;
    tick();
    tick();
    chk("wr grant", bus.ch_grant, 3'b100);
    bus.ch_wr_req = '0;
    for (int i = 0; i < 4; i++) begin
      bus.app_wdf_rdy = wp[i];
      #1;
      chk("wr data_req", bus.ch_wr_data_req, wp[i] ? 3'b100 : 3'b000);
      chk("wr app_en", bus.app_en, 1);
      chk("wr wren", bus.app_wdf_wren, 1);
      chk("wr app_cmd", bus.app_cmd, 3'b000);
      chk("wr app_addr", bus.app_addr, wa[i]);
      chk("wr wdf_data", bus.app_wdf_data, 128'hC2C2_0000_1111_2222_3333_4444_5555_6666);
      tick();
    end
    bus.app_wdf_rdy = 1;
    #1;
    chk("wr done", bus.ch_done, 3'b100);
    chk("wr app_en off", bus.app_en, 0);
    chk("wr data_req off", bus.ch_wr_data_req, 0);
    tick();
    set_ch(0, 28'h0, 1);
    set_ch(1, 28'h0, 1);
    set_ch(2, 28'h0, 1);
    bus.app_rd_data_valid = 1;
    bus.ch_rd_req = 3'b111;
    for (int b = 0; b < 4; b++) begin
      for (int t = 0; t < 10 && bus.ch_grant == 0; t++) tick();
      chk("rr grant", bus.ch_grant, rr_exp[b]);
      for (int t = 0; t < 10 && bus.ch_done == 0; t++) tick();
      chk("rr done", bus.ch_done, rr_exp[b]);
      tick();
    end
    bus.ch_rd_req = '0;
    bus.app_rd_data_valid = 0;
    repeat (3) tick();
    set_ch(0, 28'h0, 0);
    bus.ch_wr_req = 3'b001;
    tick();
    chk("z arb app_en", bus.app_en, 0);
    tick();
    chk("z done", bus.ch_done, 3'b001);
    chk("z app_en", bus.app_en, 0);
    bus.ch_wr_req = '0;
    tick();
    chk("z done off", bus.ch_done, 0);
    chk("z idle app_en", bus.app_en, 0);
    set_ch(1, 28'h100, 4);
    bus.ch_rd_req = 3'b010;
    tick();
    tick();
    bus.ch_rd_req = '0;
    #1;
    chk("ab addr0", bus.app_addr, 28'h100);
    tick();
    tick();
    chk("ab addr2", bus.app_addr, 28'h110);
    chk("ab app_en", bus.app_en, 1);
    bus.app_rd_data_valid = 1;
    bus.app_rd_data = 128'hEE;
    rst = 0;
    #1;
    chk("ab app_en rst", bus.app_en, 0);
    chk("ab grant rst", bus.ch_grant, 0);
    chk("ab addr rst", bus.app_addr, 0);
    chk("ab rd_valid rst", bus.ch_rd_data_valid, 0);
    chk("ab rd_data rst", bus.ch_rd_data, 0);
    tick();
    tick();
    rst = 1;
    tick();
    chk("ab discard", bus.ch_rd_data_valid, 0);
    bus.app_rd_data_valid = 0;
    set_ch(0, 28'h0, 1);
    set_ch(1, 28'h0, 1);
    set_ch(2, 28'h0, 1);
    bus.ch_rd_req = 3'b111;
    tick();
    tick();
    chk("ab rr grant", bus.ch_grant, 3'b001);
    bus.ch_rd_req = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
